// File: rtl/scrambler_pkg.sv
// Shared constants and LFSR helpers for the PCIe Gen1/Gen2 transmit scrambler.
// The polynomial is G(X)=X^16+X^5+X^4+X^3+1 in Galois form.
package scrambler_pkg;

    localparam logic [15:0] SEED    = 16'hFFFF;
    localparam logic [7:0]  COM_SYM = 8'hBC;
    localparam logic [7:0]  SKP_SYM = 8'h1C;

    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_32 = 2'b10;

    function automatic logic [15:0] lfsr_step1(input logic [15:0] l);
        logic [15:0] n;
        n    = {l[14:0], l[15]};
        n[3] = l[2] ^ l[15];
        n[4] = l[3] ^ l[15];
        n[5] = l[4] ^ l[15];
        return n;
    endfunction

    function automatic logic [15:0] lfsr_step8(input logic [15:0] l);
        logic [15:0] n;
        n = l;
        for (int i = 0; i < 8; i++) begin
            n = lfsr_step1(n);
        end
        return n;
    endfunction

endpackage

// File: rtl/scrambler_byte.sv
// One symbol lane of the scrambler: scrambles a data byte or applies the
// COM/SKP/other-K rule, and hands the resulting LFSR state to the next lane.
module scrambler_byte
    import scrambler_pkg::*;
#(
    parameter logic [15:0] SEED_VAL = scrambler_pkg::SEED,
    parameter logic [7:0]  COM_VAL  = scrambler_pkg::COM_SYM,
    parameter logic [7:0]  SKP_VAL  = scrambler_pkg::SKP_SYM
) (
    input  logic [7:0]  byte_i,
    input  logic        k_i,
    input  logic [15:0] lfsr_i,
    output logic [7:0]  byte_o,
    output logic [15:0] lfsr_o
);

    logic [15:0] l;

    always_comb begin
        byte_o = byte_i;
        lfsr_o = lfsr_step8(lfsr_i);
        l      = lfsr_i;
        if (k_i) begin
            if (byte_i == COM_VAL) begin
                lfsr_o = SEED_VAL;
            end else if (byte_i == SKP_VAL) begin
                lfsr_o = lfsr_i;
            end
        end else begin
            // LSB first: each bit sees the state before its own step.
            for (int k = 0; k < 8; k++) begin
                byte_o[k] = byte_i[k] ^ l[15];
                l         = lfsr_step1(l);
            end
            lfsr_o = l;
        end
    end

endmodule

// File: rtl/scrambler_top.sv
// PCIe transmit scrambler: four chained byte lanes, valid-lane selection of the
// final LFSR state, zeroing of unused lanes, and one register stage.
module scrambler_top #(
    parameter logic [15:0] SEED    = scrambler_pkg::SEED,
    parameter logic [7:0]  COM_SYM = scrambler_pkg::COM_SYM,
    parameter logic [7:0]  SKP_SYM = scrambler_pkg::SKP_SYM
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] indata_i,
    input  logic [3:0]  datak_i,
    input  logic [1:0]  data_len_i,
    output logic [31:0] scrambled_data_o
);

    import scrambler_pkg::LEN_8;
    import scrambler_pkg::LEN_16;

    logic [15:0] lfsr;
    logic [15:0] lfsr_chain [0:4];
    logic [31:0] lane_data;
    logic [15:0] lfsr_next;
    logic [3:0]  lane_valid;
    logic [31:0] data_next;

    assign lfsr_chain[0] = lfsr;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        scrambler_byte #(
            .SEED_VAL (SEED),
            .COM_VAL  (COM_SYM),
            .SKP_VAL  (SKP_SYM)
        ) u_byte (
            .byte_i (indata_i[8*g +: 8]),
            .k_i    (datak_i[g]),
            .lfsr_i (lfsr_chain[g]),
            .byte_o (lane_data[8*g +: 8]),
            .lfsr_o (lfsr_chain[g+1])
        );
    end

    // Length 2'b11 is handled as a full 4-symbol word.
    always_comb begin
        lfsr_next  = lfsr_chain[4];
        lane_valid = 4'b1111;
        case (data_len_i)
            LEN_8: begin
                lfsr_next  = lfsr_chain[1];
                lane_valid = 4'b0001;
            end
            LEN_16: begin
                lfsr_next  = lfsr_chain[2];
                lane_valid = 4'b0011;
            end
            default: begin
                lfsr_next  = lfsr_chain[4];
                lane_valid = 4'b1111;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            data_next[8*i +: 8] = lane_valid[i] ? lane_data[8*i +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr             <= SEED;
            scrambled_data_o <= 32'h0;
        end else begin
            lfsr             <= lfsr_next;
            scrambled_data_o <= data_next;
        end
    end

endmodule

// File: tb/tb_scrambler_top.sv
// Directed bench for scrambler_top: a chained vector table plus per-length
// COM / SKP / zero-data sequences checked against the known PCIe byte stream.
module tb_scrambler_top;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] indata_i;
    logic [3:0]  datak_i;
    logic [1:0]  data_len_i;
    logic [31:0] scrambled_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    scrambler_top dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .indata_i         (indata_i),
        .datak_i          (datak_i),
        .data_len_i       (data_len_i),
        .scrambled_data_o (scrambled_data_o)
    );

    typedef struct {
        logic        rst;
        logic [31:0] data;
        logic [3:0]  k;
        logic [1:0]  len;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [18];
    logic [7:0] seq [12];

    task automatic drive_and_check(input logic rst, input logic [31:0] data,
                                   input logic [3:0] k, input logic [1:0] len,
                                   input logic [31:0] exp, input string name);
        @(negedge clk_i);
        rst_i      = rst;
        indata_i   = data;
        datak_i    = k;
        data_len_i = len;
        @(posedge clk_i);
        #1;
        checks++;
        if (scrambled_data_o !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, scrambled_data_o, exp);
        end
    endtask

    initial begin
        rst_i      = 1'b1;
        indata_i   = 32'h0;
        datak_i    = 4'h0;
        data_len_i = 2'b00;

        seq = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7,
                8'h02, 8'h82, 8'h72, 8'h6E, 8'h28, 8'hA6};

        vecs[0]  = '{1'b1, 32'h12345678, 4'hF, 2'b10, 32'h00000000, "reset"};
        vecs[1]  = '{1'b0, 32'h00000000, 4'h0, 2'b00, 32'h000000FF, "first_byte"};
        vecs[2]  = '{1'b0, 32'h000000BC, 4'h1, 2'b10, 32'hC017FFBC, "com_word"};
        vecs[3]  = '{1'b0, 32'h001C0000, 4'h4, 2'b10, 32'hE71CB214, "skp_lane2"};
        vecs[4]  = '{1'b0, 32'h00000000, 4'h0, 2'b01, 32'h00008202, "len16"};
        vecs[5]  = '{1'b0, 32'h00000000, 4'h0, 2'b10, 32'hA6286E72, "len32"};
        vecs[6]  = '{1'b1, 32'h000000BC, 4'h1, 2'b10, 32'h00000000, "mid_reset"};
        vecs[7]  = '{1'b0, 32'h00000000, 4'h0, 2'b00, 32'h000000FF, "after_reset"};
        vecs[8]  = '{1'b0, 32'h000000BC, 4'h0, 2'b00, 32'h000000AB, "bc_as_data"};
        vecs[9]  = '{1'b0, 32'h0000BC00, 4'h2, 2'b00, 32'h000000C0, "invalid_lane_com"};
        vecs[10] = '{1'b0, 32'h00000000, 4'h0, 2'b11, 32'h02E7B214, "len11_as_32"};
        vecs[11] = '{1'b0, 32'h0000003C, 4'h1, 2'b00, 32'h0000003C, "other_k"};
        vecs[12] = '{1'b0, 32'h00000000, 4'h0, 2'b00, 32'h00000072, "after_other_k"};
        vecs[13] = '{1'b0, 32'h0000BC00, 4'h2, 2'b01, 32'h0000BC6E, "com_lane1"};
        vecs[14] = '{1'b0, 32'h0000BCBC, 4'h3, 2'b10, 32'h17FFBCBC, "double_com"};
        vecs[15] = '{1'b0, 32'h00000000, 4'h0, 2'b00, 32'h000000C0, "after_double_com"};
        vecs[16] = '{1'b1, 32'h00000000, 4'h0, 2'b10, 32'h00000000, "reset_again"};
        vecs[17] = '{1'b0, 32'h00000000, 4'h0, 2'b00, 32'h000000FF, "reseeded"};

        for (int i = 0; i < 18; i++) begin
            drive_and_check(vecs[i].rst, vecs[i].data, vecs[i].k, vecs[i].len,
                            vecs[i].exp, vecs[i].name);
        end

        // COM, then an all-SKP word, then zero data, for each symbol width.
        for (int l = 0; l < 3; l++) begin
            int          nb;
            int          idx;
            logic [3:0]  mask;
            logic [31:0] exp;
            logic [31:0] skp;
            nb   = (l == 0) ? 1 : (l == 1) ? 2 : 4;
            mask = (l == 0) ? 4'b0001 : (l == 1) ? 4'b0011 : 4'b1111;

            drive_and_check(1'b1, 32'h0, 4'h0, 2'(l), 32'h0, "seq_reset");

            exp = 32'h000000BC;
            for (int b = 1; b < nb; b++) exp[8*b +: 8] = seq[b-1];
            drive_and_check(1'b0, 32'h000000BC, 4'b0001, 2'(l), exp, "seq_com");
            idx = nb - 1;

            skp = 32'h0;
            for (int b = 0; b < nb; b++) skp[8*b +: 8] = 8'h1C;
            drive_and_check(1'b0, 32'h1C1C1C1C, mask, 2'(l), skp, "seq_skp");

            while (idx < 8) begin
                exp = 32'h0;
                for (int b = 0; b < nb; b++) exp[8*b +: 8] = seq[idx+b];
                drive_and_check(1'b0, 32'h0, 4'h0, 2'(l), exp, "seq_data");
                idx += nb;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scrambler_top.md
Name: scrambler_top

Overview:
- PCIe Gen1/Gen2 transmit scrambler using the 16-bit LFSR G(X)=X^16+X^5+X^4+X^3+1.
- Sits between the PIPE transmit data path and the 8b/10b encoder.
- Takes 1, 2 or 4 symbols per clock, with a per-byte K flag.
- Outputs registered, scrambled symbols; K symbols pass through unchanged.

Parameters:
SEED, 16'hFFFF, LFSR init value on reset and on COM
COM_SYM, 8'hBC, K28.5 (COM) byte value
SKP_SYM, 8'h1C, K28.0 (SKP) byte value

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous, active-high reset
indata_i  input  32  symbols; byte0 [7:0] is first in time, byte3 [31:24] is last
datak_i  input  4  per-byte K flag; bit n belongs to byte n
data_len_i  input  2  symbols valid this cycle: 00=1 (byte0), 01=2 (bytes0-1), 10=4 (bytes0-3), 11=treated as 10
scrambled_data_o  output  32  registered scrambled symbols, same lane order

Behaviour:
- Reset (synchronous, rst_i=1 at posedge): lfsr <= SEED; scrambled_data_o <= 0.
- Valid bytes are processed in order, byte0 to the highest valid byte. The LFSR state is chained combinationally through them within one cycle.
- Per byte, given current state L:
  - K and value==COM_SYM: output the byte unchanged; state becomes SEED.
  - K and value==SKP_SYM: output the byte unchanged; state stays L (no advance).
  - Any other K byte: output the byte unchanged; state advances 8 steps.
  - Data byte: for bit k=0..7 (LSB first), out[k]=in[k]^L[15], then advance one step. The net result is 8 steps.
- One LFSR step (Galois form):
  - n[0]=L[15]
  - n[3]=L[2]^L[15]; n[4]=L[3]^L[15]; n[5]=L[4]^L[15]
  - all other n[i]=L[i-1]
- The state after the last valid byte is registered into lfsr.
- Invalid lanes (beyond data_len_i):
  - input ignored, does not touch the LFSR
  - output lane driven 8'h00
- Latency: 1 clock. Inputs sampled at posedge t appear on scrambled_data_o after posedge t.
- data_len_i may change every cycle. There is no stall or valid handshake: every non-reset cycle consumes the indicated symbols.
- The K flag is required for COM/SKP detection. 8'hBC or 8'h1C with K=0 are ordinary data and get scrambled.
- Multiple COMs in one word: each COM reseeds, so bytes after the last COM use the sequence starting from SEED.
- Reset asserted mid-stream overrides everything that cycle.

Decomposition:
- Package scrambler_pkg holds:
  - COM_SYM, SKP_SYM, SEED
  - data_len encodings LEN_8=2'b00, LEN_16=2'b01, LEN_32=2'b10
  - a function lfsr_step8 (8 Galois steps)
- Sub-module scrambler_byte: purely combinational; ports byte in, K in, lfsr in, byte out, lfsr out.
- The top instantiates four scrambler_byte in a chain and adds:
  - a valid-lane mux selecting the final lfsr
  - output zeroing of invalid lanes
  - the output and state registers

Test Plan:
- Reset, then 1-symbol data 8'h00 with K=0 -> scrambled_data_o = 32'h000000FF one cycle later.
- 32-bit word indata_i=32'h000000BC, datak_i=4'b0001 (COM then three 00 data bytes) -> 32'hC017FFBC.
- Next, indata_i=32'h001C0000, datak_i=4'b0100, 32-bit (SKP in byte2, no advance) -> 32'hE71CB214.
- Next, 16-bit zero data -> 32'h00008202; next 32-bit zero data -> 32'hA6286E72.
- SKP-only sequence after COM does not perturb the stream: for each data_len (00, 01, 10), COM then zero data -> bytes FF 17 C0 14 B2 E7 02 82 in order across cycles.
- Assert rst_i mid-stream -> output 0 next cycle. After release, the next 1-symbol zero data byte gives 8'hFF. Data bytes 8'hBC with K=0 are scrambled, not treated as COM.
